mux_rr_arbiter8: RTL and testbench
==================================

# mux_rr_arbiter8

Round-robin arbiter and select sequencer for the 8-to-1 enabled bit multiplexer. Eight requesters compete for the shared mux output. The block grants one requester at a time, drives the mux select and enable from registered state, and bounds each tenure to `MAX_HOLD` cycles. It sits directly upstream of the mux: `sel` connects to the mux select, and `en` connects to the mux enable.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may last; legal range 1..15.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; `req[i]` high means requester i wants the mux. Level-sensitive.
- `sel`  out  3  index of the current owner; drives the mux select.
- `en`  out  1  high while a grant is active; drives the mux enable (mux output is 0 when low).
- `gnt`  out  8  one-hot grant; `gnt[sel]` equals `en`, all other bits 0.

## Operation
- States:
  - IDLE: no owner; `en`=0, `gnt`=0.
  - GRANT: owner = `sel`; `en`=1.
- Internal registers:
  - `ptr[2:0]`: round-robin start index.
  - `cnt[3:0]`: cycles held in the current tenure.
- Pick function (combinational):
  - Scan `req` starting at index `ptr` and wrapping 7→0.
  - The first set bit wins; no request means no winner.
- IDLE:
  - If any `req` bit is set at the edge: go to GRANT, `sel`=winner, `cnt`=1.
  - Otherwise stay in IDLE.
- GRANT: release occurs at an edge when `req[sel]`=0 or `cnt`==`MAX_HOLD`.
  - On release, `ptr` becomes `sel`+1 mod 8, so the outgoing owner is scanned last.
  - Re-pick in the same edge using the new `ptr`:
    - Winner found: stay in GRANT, `sel`=winner, `cnt`=1. No idle bubble between owners.
    - No winner: go to IDLE; `sel` holds its last value.
  - No release: `cnt` increments and the owner is unchanged.
- Sole requester at `MAX_HOLD` expiry: the same index is re-granted.
  - `en` stays 1, `sel` is unchanged, `cnt` reloads to 1.
- `req` changes of non-owners never preempt the current owner.
- Width rules:
  - `cnt` never exceeds `MAX_HOLD`.
  - `ptr` and `sel` wrap modulo 8.
- Reset, including during GRANT:
  - At the reset edge: state IDLE, `sel`=0, `en`=0, `gnt`=0, `ptr`=0, `cnt`=0.
  - All requests are ignored while `rst`=1.

## Timing
- All outputs are registered; there are no combinational paths from `req` to outputs.
- Grant latency: `req[i]` first high in cycle N (IDLE) → `gnt[i]`/`en`/`sel`=i valid in cycle N+1.
- Release lag: owner drops `req` in cycle M → grant remains visible in cycle M; the new owner or IDLE appears in M+1.
- Maximum tenure is `MAX_HOLD` consecutive cycles whenever any other requester is pending.
- Worst-case wait for a continuously asserting requester is 7×`MAX_HOLD` cycles after its request is sampled.
- Outputs during reset:
  - `rst` high in cycle R → outputs are at reset values from cycle R+1.
  - The first grant is possible in the cycle after the first edge with `rst`=0 and a request present.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=8'hFF → `en`=0, `gnt`=0, `sel`=0 throughout. Then release `rst` → next cycle `gnt`=8'h01, `sel`=0.
- Single tenure (`MAX_HOLD`=4): `req`=8'h20 for 3 cycles, then 0 → `gnt`=8'h20, `sel`=5, `en`=1 for exactly 3 cycles, starting one cycle after `req` rises. Then `en`=0, `gnt`=0.
- Full contention: `req`=8'hFF held, `MAX_HOLD`=4 → `sel` = 0,0,0,0,1,1,1,1,…,7,7,7,7,0. `en` is never 0 and the wrap from 7 to 0 is seamless.
- Fairness: `req`=8'b1000_0001 after owner 0's tenure expires → `sel`=7 for 4 cycles, then 0 for 4 cycles, alternating.
- Sole requester: `req`=8'h08 held for 10 cycles, `MAX_HOLD`=4 → `en`=1 and `sel`=3 continuously across the expiry/re-grant boundaries.
- Reset mid-grant: owner 2 in cycle 2 of its tenure, assert `rst` for 1 cycle with `req`=8'h04 still high → next cycle `en`=0, `gnt`=0, `sel`=0. The cycle after `rst` drops → `gnt`=8'h04 with `cnt` restarted.

Source files
------------

// File: rtl/mux_rr_arbiter8.sv
// Round-robin arbiter driving the select/enable of an 8-to-1 enabled bit mux.
// One owner at a time, tenure bounded to MAX_HOLD cycles, all outputs registered.
module mux_rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] gnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;

  logic       release_now;
  logic [2:0] scan_ptr;
  logic [7:0] req_rot;
  logic       win_found;
  logic [2:0] win_idx;

  assign release_now = (state_q == S_GRANT) &&
                       (!req[sel_q] || (cnt_q == 4'(MAX_HOLD)));

  // On release the scan starts just past the outgoing owner, so it is checked last.
  assign scan_ptr = release_now ? (sel_q + 3'd1) : ptr_q;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req[scan_ptr + 3'(gi)];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_found = 1'b1;
        win_idx   = scan_ptr + 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          sel_d   = win_idx;
          cnt_d   = 4'd1;
        end
      end
      default: begin
        if (release_now) begin
          ptr_d = sel_q + 3'd1;
          if (win_found) begin
            sel_d = win_idx;
            cnt_d = 4'd1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
    gnt_d = (state_d == S_GRANT) ? (8'd1 << sel_d) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign sel = sel_q;
  assign en  = (state_q == S_GRANT);
  assign gnt = gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter8.sv
// Directed bench for mux_rr_arbiter8 (MAX_HOLD = 4) with hand-computed expectations.
module tb_mux_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;

  int vectors;
  int miscompares;

  mux_rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .sel(sel),
    .en (en),
    .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then compare outputs 1 time unit after it.
  task automatic tick_check(input string tag, input logic exp_en,
                            input logic [2:0] exp_sel, input logic [7:0] exp_gnt);
    logic [11:0] obs;
    logic [11:0] exp_v;
    @(posedge clk);
    #1;
    obs   = {en, sel, gnt};
    exp_v = {exp_en, exp_sel, exp_gnt};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed en=%b sel=%0d gnt=%h, expected en=%b sel=%0d gnt=%h",
             tag, en, sel, gnt, exp_en, exp_sel, exp_gnt);
    end
    $display("vec %0d %s req=%h rst=%b -> en=%b sel=%0d gnt=%h",
             vectors, tag, req, rst, en, sel, gnt);
  endtask

  initial begin
    logic [2:0] s;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    req = 8'hFF;

    // Reset held two cycles with every request high.
    tick_check("reset0", 1'b0, 3'd0, 8'h00);
    tick_check("reset1", 1'b0, 3'd0, 8'h00);
    rst = 1'b0;
    tick_check("first_grant", 1'b1, 3'd0, 8'h01);
    req = 8'h00;
    tick_check("drop_to_idle", 1'b0, 3'd0, 8'h00);

    // Single tenure on requester 5 for three cycles.
    req = 8'h20;
    tick_check("single_t1", 1'b1, 3'd5, 8'h20);
    tick_check("single_t2", 1'b1, 3'd5, 8'h20);
    tick_check("single_t3", 1'b1, 3'd5, 8'h20);
    req = 8'h00;
    tick_check("single_idle", 1'b0, 3'd5, 8'h00);

    // Full contention from a fresh reset: 4 cycles per owner, seamless wrap.
    rst = 1'b1;
    req = 8'hFF;
    tick_check("reset2", 1'b0, 3'd0, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 33; k++) begin
      s = 3'((k / 4) % 8);
      tick_check("contention", 1'b1, s, 8'd1 << s);
    end

    // Fairness between 7 and 0; owner 0 is in cycle 1 of its tenure here.
    req = 8'h81;
    tick_check("fair_pre0", 1'b1, 3'd0, 8'h01);
    tick_check("fair_pre1", 1'b1, 3'd0, 8'h01);
    tick_check("fair_pre2", 1'b1, 3'd0, 8'h01);
    for (int k = 0; k < 12; k++) begin
      s = (((k / 4) % 2) == 0) ? 3'd7 : 3'd0;
      tick_check("fairness", 1'b1, s, 8'd1 << s);
    end
    req = 8'h00;
    tick_check("fair_idle", 1'b0, 3'd7, 8'h00);

    // Sole requester re-granted across expiry with no bubble.
    req = 8'h08;
    for (int k = 0; k < 10; k++) begin
      tick_check("sole_req", 1'b1, 3'd3, 8'h08);
    end
    req = 8'h00;
    tick_check("sole_idle", 1'b0, 3'd3, 8'h00);

    // Reset in cycle 2 of owner 2's tenure.
    req = 8'h04;
    tick_check("mid_c1", 1'b1, 3'd2, 8'h04);
    tick_check("mid_c2", 1'b1, 3'd2, 8'h04);
    rst = 1'b1;
    tick_check("mid_reset", 1'b0, 3'd0, 8'h00);
    rst = 1'b0;
    tick_check("post_reset_grant", 1'b1, 3'd2, 8'h04);
    // A full fresh tenure of 4 must follow before requester 0 gets in.
    req = 8'h05;
    tick_check("restart_c2", 1'b1, 3'd2, 8'h04);
    tick_check("restart_c3", 1'b1, 3'd2, 8'h04);
    tick_check("restart_c4", 1'b1, 3'd2, 8'h04);
    tick_check("handoff_to_0", 1'b1, 3'd0, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
